// File: rtl/elevator_pkg.sv
// elevator_pkg: shared encodings and defaults for the elevator controller.
//   - running_state / door_state one-hot output codes
//   - scheduler FSM state encoding and travel-direction memory encoding
//   - default tick durations (10 Hz clock)
// The floor count comes from the `F_N define (default 4).
`ifndef F_N
`define F_N 4
`endif

package elevator_pkg;

    localparam int F_N_DEF = `F_N;

    localparam int CNT_W = 8;

    localparam int TRAVEL_TICKS_DEF    = 20;
    localparam int DOOR_MOVE_TICKS_DEF = 10;
    localparam int DOOR_HOLD_TICKS_DEF = 30;

    localparam logic [3:0] RUN_IDLE    = 4'b0001;
    localparam logic [3:0] RUN_UP      = 4'b0010;
    localparam logic [3:0] RUN_DOWN    = 4'b0100;
    localparam logic [3:0] RUN_STOPPED = 4'b1000;

    localparam logic [3:0] DOOR_OPENING_OH = 4'b0001;
    localparam logic [3:0] DOOR_OPEN_OH    = 4'b0010;
    localparam logic [3:0] DOOR_CLOSED_OH  = 4'b0100;
    localparam logic [3:0] DOOR_CLOSING_OH = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_DOOR_OPENING,
        ST_DOOR_OPEN,
        ST_DOOR_CLOSING
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/call_finder.sv
// call_finder: combinational call locator relative to a floor.
// Ports:
//   floor_req, up_req, down_req  in  F_N  latched call vectors
//   floor                        in  8    reference floor index
//   any_here                     out 1    some call at 'floor'
//   above / below                out 1    some call strictly above / below 'floor'
// up_req[F_N-1] and down_req[0] do not correspond to real buttons and are ignored.
module call_finder
    import elevator_pkg::*;
#(
    parameter int F_N = F_N_DEF
) (
    input  logic [F_N-1:0] floor_req,
    input  logic [F_N-1:0] up_req,
    input  logic [F_N-1:0] down_req,
    input  logic [7:0]     floor,
    output logic           any_here,
    output logic           above,
    output logic           below
);

    localparam logic [F_N-1:0] UP_MASK   = {1'b0, {(F_N-1){1'b1}}};
    localparam logic [F_N-1:0] DOWN_MASK = {{(F_N-1){1'b1}}, 1'b0};

    logic [F_N-1:0] calls;

    always_comb begin
        calls    = floor_req | (up_req & UP_MASK) | (down_req & DOWN_MASK);
        any_here = 1'b0;
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < F_N; i++) begin
            if (calls[i]) begin
                if (8'(i) == floor) any_here = 1'b1;
                if (8'(i) >  floor) above    = 1'b1;
                if (8'(i) <  floor) below    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: LOOK-algorithm motion and door sequencer for one car.
// Ports:
//   clk10hz        in   1    sole clock
//   rst            in   1    synchronous reset, active-high
//   floor_req      in   F_N  pending car calls
//   up_req         in   F_N  pending hall-up calls (top bit ignored)
//   down_req       in   F_N  pending hall-down calls (bit 0 ignored)
//   curr_floor     out  8    binary floor index
//   running_state  out  4    one-hot IDLE/UP/DOWN/STOPPED
//   door_state     out  4    one-hot OPENING/OPEN/CLOSED/CLOSING
//   clr_floor/up/down out F_N one-cycle clear pulses for served calls
// Build option: define DOOR_REOPEN_EN to let a call at the current floor
// abort a closing door and reopen it immediately.
`ifndef F_N
`define F_N 4
`endif

module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int F_N             = `F_N,
    parameter int TRAVEL_TICKS    = TRAVEL_TICKS_DEF,
    parameter int DOOR_MOVE_TICKS = DOOR_MOVE_TICKS_DEF,
    parameter int DOOR_HOLD_TICKS = DOOR_HOLD_TICKS_DEF
) (
    input  logic           clk10hz,
    input  logic           rst,
    input  logic [F_N-1:0] floor_req,
    input  logic [F_N-1:0] up_req,
    input  logic [F_N-1:0] down_req,
    output logic [7:0]     curr_floor,
    output logic [3:0]     running_state,
    output logic [3:0]     door_state,
    output logic [F_N-1:0] clr_floor,
    output logic [F_N-1:0] clr_up,
    output logic [F_N-1:0] clr_down
);

    localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] MOVE_LD   = CNT_W'(DOOR_MOVE_TICKS - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(DOOR_HOLD_TICKS - 1);
    localparam logic [7:0]       TOP_FLOOR = 8'(F_N - 1);

    state_t           state, state_nx;
    dir_t             dir_mem, dir_nx;
    logic [7:0]       floor_nx, next_floor;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [F_N-1:0]   clr_floor_nx, clr_up_nx, clr_down_nx;

    logic here_any, here_above, here_below;
    logic nf_any, nf_above, nf_below;
    logic fr_cur, up_cur, fr_nf, up_nf, dn_nf;

    // Floor the car reaches when the current travel step completes.
    assign next_floor = (state == ST_MOVE_DOWN) ? curr_floor - 8'd1 : curr_floor + 8'd1;

    call_finder #(.F_N(F_N)) u_find_here (
        .floor_req (floor_req),
        .up_req    (up_req),
        .down_req  (down_req),
        .floor     (curr_floor),
        .any_here  (here_any),
        .above     (here_above),
        .below     (here_below)
    );

    call_finder #(.F_N(F_N)) u_find_next (
        .floor_req (floor_req),
        .up_req    (up_req),
        .down_req  (down_req),
        .floor     (next_floor),
        .any_here  (nf_any),
        .above     (nf_above),
        .below     (nf_below)
    );

    // Individual call bits at the current and the arriving floor.
    always_comb begin
        fr_cur = 1'b0;
        up_cur = 1'b0;
        fr_nf  = 1'b0;
        up_nf  = 1'b0;
        dn_nf  = 1'b0;
        for (int i = 0; i < F_N; i++) begin
            if (8'(i) == curr_floor) begin
                fr_cur = floor_req[i];
                up_cur = up_req[i] && (i != F_N - 1);
            end
            if (8'(i) == next_floor) begin
                fr_nf = floor_req[i];
                up_nf = up_req[i] && (i != F_N - 1);
                dn_nf = down_req[i] && (i != 0);
            end
        end
    end

    always_ff @(posedge clk10hz) begin
        if (rst) begin
            state      <= ST_IDLE;
            dir_mem    <= DIR_UP;
            curr_floor <= 8'd0;
            cnt        <= '0;
            clr_floor  <= '0;
            clr_up     <= '0;
            clr_down   <= '0;
        end else begin
            state      <= state_nx;
            dir_mem    <= dir_nx;
            curr_floor <= floor_nx;
            cnt        <= cnt_nx;
            clr_floor  <= clr_floor_nx;
            clr_up     <= clr_up_nx;
            clr_down   <= clr_down_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        dir_nx       = dir_mem;
        floor_nx     = curr_floor;
        cnt_nx       = (cnt != '0) ? cnt - CNT_W'(1) : '0;
        clr_floor_nx = '0;
        clr_up_nx    = '0;
        clr_down_nx  = '0;

        case (state)
            ST_IDLE: begin
                if (here_any) begin
                    state_nx = ST_DOOR_OPENING;
                    cnt_nx   = MOVE_LD;
                    // Only an opposite hall call waits here and nothing lies ahead:
                    // turn around so that the door cycle actually clears it.
                    if (dir_mem == DIR_UP && !here_above && !fr_cur && !up_cur)
                        dir_nx = DIR_DOWN;
                    else if (dir_mem == DIR_DOWN && !here_below && !fr_cur && up_cur)
                        dir_nx = DIR_UP;
                end else if (dir_mem == DIR_UP) begin
                    if (here_above) begin
                        state_nx = ST_MOVE_UP;
                        cnt_nx   = TRAVEL_LD;
                    end else if (here_below) begin
                        state_nx = ST_MOVE_DOWN;
                        cnt_nx   = TRAVEL_LD;
                    end
                end else begin
                    if (here_below) begin
                        state_nx = ST_MOVE_DOWN;
                        cnt_nx   = TRAVEL_LD;
                    end else if (here_above) begin
                        state_nx = ST_MOVE_UP;
                        cnt_nx   = TRAVEL_LD;
                    end
                end
            end

            ST_MOVE_UP: begin
                if (cnt == '0) begin
                    floor_nx = next_floor;
                    dir_nx   = DIR_UP;
                    if (fr_nf || up_nf || !nf_above) begin
                        state_nx = ST_DOOR_OPENING;
                        cnt_nx   = MOVE_LD;
                        if (!nf_above && nf_any && !fr_nf && !up_nf)
                            dir_nx = DIR_DOWN;
                    end else begin
                        cnt_nx = TRAVEL_LD;
                    end
                    if (next_floor == TOP_FLOOR)
                        dir_nx = DIR_DOWN;
                end
            end

            ST_MOVE_DOWN: begin
                if (cnt == '0) begin
                    floor_nx = next_floor;
                    dir_nx   = DIR_DOWN;
                    if (fr_nf || dn_nf || !nf_below) begin
                        state_nx = ST_DOOR_OPENING;
                        cnt_nx   = MOVE_LD;
                        if (!nf_below && nf_any && !fr_nf && !dn_nf)
                            dir_nx = DIR_UP;
                    end else begin
                        cnt_nx = TRAVEL_LD;
                    end
                    if (next_floor == 8'd0)
                        dir_nx = DIR_UP;
                end
            end

            ST_DOOR_OPENING: begin
                if (cnt == '0) begin
                    state_nx = ST_DOOR_OPEN;
                    cnt_nx   = HOLD_LD;
                    for (int i = 0; i < F_N; i++) begin
                        if (8'(i) == curr_floor) begin
                            clr_floor_nx[i] = 1'b1;
                            if (dir_mem == DIR_UP) clr_up_nx[i]   = 1'b1;
                            else                   clr_down_nx[i] = 1'b1;
                            // Last stop of the trip: drop every call left here.
                            if (!here_above && !here_below) begin
                                clr_up_nx[i]   = clr_up_nx[i]   | (up_req[i] && (i != F_N - 1));
                                clr_down_nx[i] = clr_down_nx[i] | (down_req[i] && (i != 0));
                            end
                        end
                    end
                end
            end

            ST_DOOR_OPEN: begin
                if (cnt == '0) begin
                    state_nx = ST_DOOR_CLOSING;
                    cnt_nx   = MOVE_LD;
                end
            end

            ST_DOOR_CLOSING: begin
`ifdef DOOR_REOPEN_EN
                if (here_any) begin
                    state_nx = ST_DOOR_OPENING;
                    cnt_nx   = MOVE_LD;
                end else if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end
`else
                if (cnt == '0)
                    state_nx = ST_IDLE;
`endif
            end

            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_comb begin
        running_state = RUN_IDLE;
        door_state    = DOOR_CLOSED_OH;
        case (state)
            ST_MOVE_UP:      running_state = RUN_UP;
            ST_MOVE_DOWN:    running_state = RUN_DOWN;
            ST_DOOR_OPENING: begin
                running_state = RUN_STOPPED;
                door_state    = DOOR_OPENING_OH;
            end
            ST_DOOR_OPEN: begin
                running_state = RUN_STOPPED;
                door_state    = DOOR_OPEN_OH;
            end
            ST_DOOR_CLOSING: begin
                running_state = RUN_STOPPED;
                door_state    = DOOR_CLOSING_OH;
            end
            default: begin
                running_state = RUN_IDLE;
                door_state    = DOOR_CLOSED_OH;
            end
        endcase
    end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- LOOK-algorithm motion and door sequencer for the single elevator car.
- Consumes the latched call vectors held by the request block (car, hall-up and hall-down) and owns the car position, the direction of travel and the door timing.
- Drives curr_floor, running_state and door_state back to the request block and display.
- Issues one-cycle clear pulses when calls are served.

Parameters:
- F_N, 4, number of floors; taken from the `F_N define.
- TRAVEL_TICKS, 20, clock cycles per floor of travel (2 s at 10 Hz).
- DOOR_MOVE_TICKS, 10, cycles spent in door OPENING and in door CLOSING.
- DOOR_HOLD_TICKS, 30, cycles the door is held fully OPEN.

Ports:
- clk10hz  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- floor_req  in  F_N  pending car calls, bit i = floor i.
- up_req  in  F_N  pending hall-up calls; bit F_N-1 is ignored.
- down_req  in  F_N  pending hall-down calls; bit 0 is ignored.
- curr_floor  out  8  binary floor index, 0..F_N-1.
- running_state  out  4  one-hot: 0001 IDLE, 0010 UP, 0100 DOWN, 1000 STOPPED (door cycle).
- door_state  out  4  one-hot: 0001 OPENING, 0010 OPEN, 0100 CLOSED, 1000 CLOSING.
- clr_floor  out  F_N  one-cycle clear pulses for car calls.
- clr_up  out  F_N  one-cycle clear pulses for hall-up calls.
- clr_down  out  F_N  one-cycle clear pulses for hall-down calls.

Behaviour:
- Reset values:
  - state IDLE, curr_floor 0, running_state 0001, door_state 0100.
  - dir_mem UP, tick counter 0, all clr_* outputs 0.
  - A reset mid-travel or mid-door abandons the operation immediately.
- Definitions:
  - any_here: floor_req, up_req or down_req has the bit for curr_floor set.
  - above / below: any call bit at an index strictly greater / strictly less than curr_floor.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPENING, DOOR_OPEN, DOOR_CLOSING.
- IDLE transitions, first match wins:
  1. any_here -> DOOR_OPENING.
  2. dir_mem = UP: above -> MOVE_UP; else below -> MOVE_DOWN.
  3. dir_mem = DOWN: the mirror of rule 2.
  4. No call -> stay in IDLE.
- Every state entry loads the counter with its duration minus 1. The counter decrements each cycle, and the state's action fires on the cycle the counter reads 0.
- MOVE_UP / MOVE_DOWN:
  - At counter 0, curr_floor is incremented or decremented and dir_mem is set to match.
  - The new floor is then evaluated:
    - Stop (-> DOOR_OPENING) if floor_req[f] is set, the hall call in the travel direction is set, or no calls remain beyond f in that direction.
    - Otherwise reload TRAVEL_TICKS and continue.
  - If no call remains beyond f and the only call at f is the opposite-direction hall call, stop and reverse dir_mem.
  - Travel never leaves 0..F_N-1: reaching floor F_N-1 forces dir_mem DOWN, reaching floor 0 forces dir_mem UP.
- DOOR_OPENING -> DOOR_OPEN after DOOR_MOVE_TICKS cycles.
  - On that transition edge, clr_floor[f] pulses, together with clr_up[f] if dir_mem = UP or clr_down[f] if dir_mem = DOWN.
  - If no calls remain at all, every set bit at f is cleared.
- DOOR_OPEN -> DOOR_CLOSING after DOOR_HOLD_TICKS cycles.
- DOOR_CLOSING -> IDLE after DOOR_MOVE_TICKS cycles. door_state returns to CLOSED together with running_state IDLE.
- running_state mapping: UP/DOWN while moving; STOPPED in all three door states.
- clr_* pulses are strictly one cycle and never coincide with a move.
- Call bits that change mid-travel are honoured at the next floor evaluation.
- A call that appears at the current floor during DOOR_OPEN or DOOR_CLOSING and is not cleared is served by IDLE rule 1 (reopen).

Optional Feature:
- Macro: DOOR_REOPEN_EN.
- Defined: in DOOR_CLOSING, any_here for a call not yet cleared aborts the close. The FSM goes to DOOR_OPENING with the full DOOR_MOVE_TICKS reload on the next edge, and door_state shows OPENING.
- Undefined: the close completes, and the call is served via IDLE -> DOOR_OPENING.

Decomposition:
- Shared package/header `elevator_pkg`:
  - running_state and door_state one-hot encodings.
  - FSM state encoding.
  - dir_mem encoding.
  - tick-duration defaults.
- One sub-module, `call_finder`: combinational above/below/any_here from the OR of the three call vectors and curr_floor. It is reused by the request block for its indicators.

Test Plan (bench params TRAVEL_TICKS=4, DOOR_MOVE_TICKS=2, DOOR_HOLD_TICKS=3):
- Reset, then idle with no calls -> curr_floor=0, running_state=0001, door_state=0100, all clr_*=0 for 50 cycles.
- up_req[2]=1 from floor 0:
  - running_state=0010 the cycle after the call is sampled.
  - curr_floor=1 after 4 cycles, curr_floor=2 after 8.
  - door_state OPENING for 2 cycles, clr_up[2] pulses for 1 cycle, OPEN for 3 cycles, CLOSING for 2 cycles, then running_state=0001.
- At floor 2 heading up with floor_req[3]=1 and down_req[1]=1 -> serves floor 3 first, reverses to 0100, stops at floor 1, clr_down[1] pulses.
- floor_req[0]=1 while idle at floor 0 -> immediate DOOR_OPENING, no motion, clr_floor[0] pulses.
- floor_req[2]=1 in the 1st CLOSING cycle at floor 2:
  - With DOOR_REOPEN_EN: door_state=0001 on the next edge.
  - Without: CLOSED then reopen via IDLE.
- Assert rst during MOVE_UP at counter=1 -> next edge curr_floor=0, running_state=0001, no clr pulse.
